// File: rtl/replace_policy_unit.sv
// ---------------------------------------------------------------------------
// replace_policy_unit
//
// Purpose:
//   Per-set victim-way selector for a set-associative cache. Keeps tree
//   pseudo-LRU state per set (POLICY=1) or uses a shared LFSR (POLICY=0).
//   An invalid way is always preferred. The victim for a lookup issued in
//   cycle N is presented, registered, in cycle N+1.
//
// Optional feature macro: REPLACE_WAY_LOCK_EN
//   Defined   -> lock_ways port exists; locked ways are excluded from
//                replacement unless every way is locked.
//   Undefined -> no lock_ways port; every way is a candidate.
//
// Parameters:
//   NUM_WAY  associativity, power of two, 1..16
//   NUM_SET  number of sets, power of two >= 2
//   POLICY   0 = LFSR random, 1 = tree PLRU
//
// Ports:
//   clk            clock, all state on the rising edge
//   reset          asynchronous active-low reset
//   lookup_valid   request a victim for lookup_set
//   lookup_set     set index of the lookup
//   v_ways         valid bits of lookup_set (same cycle as lookup_valid)
//   hit_valid      access touch strobe
//   hit_set        set touched by the hit
//   hit_way        one-hot way touched by the hit
//   fill_valid     refill touch strobe
//   fill_set       set touched by the fill
//   fill_way       one-hot way touched by the fill
//   lock_ways      ways excluded from replacement (macro only)
//   replace_valid  replace_way carries a fresh victim
//   replace_way    one-hot victim, registered; holds when replace_valid=0
// ---------------------------------------------------------------------------
module replace_policy_unit #(
  parameter int NUM_WAY = 4,
  parameter int NUM_SET = 64,
  parameter int POLICY  = 1,
  localparam int SET_W  = $clog2(NUM_SET)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [SET_W-1:0]   lookup_set,
  input  logic [NUM_WAY-1:0] v_ways,
  input  logic               hit_valid,
  input  logic [SET_W-1:0]   hit_set,
  input  logic [NUM_WAY-1:0] hit_way,
  input  logic               fill_valid,
  input  logic [SET_W-1:0]   fill_set,
  input  logic [NUM_WAY-1:0] fill_way,
`ifdef REPLACE_WAY_LOCK_EN
  input  logic [NUM_WAY-1:0] lock_ways,
`endif
  output logic               replace_valid,
  output logic [NUM_WAY-1:0] replace_way
);

  localparam int IDX_W  = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int NODES  = (NUM_WAY > 1) ? NUM_WAY - 1 : 1;
  localparam int LFSR_W = $clog2(NUM_WAY) + 2;

  genvar gi;

  // Isolate the lowest set bit of a mask.
  function automatic logic [NUM_WAY-1:0] lowest(input logic [NUM_WAY-1:0] m);
    return m & (~m + NUM_WAY'(1));
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_WAY-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Walk from the touched leaf up to the root. Nodes are in heap order, so a
  // child with an odd heap index is the lower subtree; its parent is then
  // pointed at the upper subtree (bit=1), and vice versa.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] st,
                                                  input logic [IDX_W-1:0] way);
    logic [NODES-1:0] r;
    int node;
    r    = st;
    node = int'(way) + NUM_WAY - 1;
    for (int l = 0; l < IDX_W; l++) begin
      r[(node - 1) / 2] = 1'(node & 1);
      node = (node - 1) / 2;
    end
    return r;
  endfunction

  // Follow the node bits from the root: 0 -> lower child, 1 -> upper child.
  function automatic logic [IDX_W-1:0] plru_walk(input logic [NODES-1:0] st);
    int node;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      node = 2 * node + 1 + int'(st[node]);
    end
    return IDX_W'(node - (NUM_WAY - 1));
  endfunction

  // Candidate mask; an all-locked set degrades to "every way is a candidate".
  logic [NUM_WAY-1:0] cand;
  always_comb begin
`ifdef REPLACE_WAY_LOCK_EN
    cand = ~lock_ways;
    if (cand == '0) cand = '1;
`else
    cand = '1;
`endif
  end

  logic [NUM_WAY-1:0] victim;
  logic               replace_valid_q;
  logic [NUM_WAY-1:0] replace_way_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      replace_valid_q <= 1'b0;
      replace_way_q   <= '0;
    end else begin
      replace_valid_q <= lookup_valid;
      if (lookup_valid) replace_way_q <= victim;
    end
  end

  assign replace_valid = replace_valid_q;
  assign replace_way   = replace_way_q;

  generate
    if (NUM_WAY == 1) begin : g_single
      logic unused_inputs;
      assign unused_inputs = ^{lookup_set, v_ways, hit_valid, hit_set, hit_way,
                               fill_valid, fill_set, fill_way, cand};
      assign victim = 1'b1;
    end else begin : g_multi
      localparam int TAP_MASK_I = (LFSR_W == 3) ? 'b110 :
                                  (LFSR_W == 4) ? 'b1100 :
                                  (LFSR_W == 5) ? 'b10100 : 'b110000;
      localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(TAP_MASK_I);

      logic [IDX_W-1:0]   policy_idx;
      logic [NUM_WAY-1:0] inv_cand;
      logic [NUM_WAY-1:0] policy_oh;
      logic               lfsr_step;
      logic [LFSR_W-1:0]  lfsr_q;
      logic [LFSR_W-1:0]  lfsr_d;

      always_comb begin
        inv_cand  = ~v_ways & cand;
        policy_oh = '0;
        policy_oh[policy_idx] = 1'b1;
        lfsr_step = 1'b0;
        victim    = lowest(cand);
        if (inv_cand != '0) begin
          victim = lowest(inv_cand);
        end else begin
          // The LFSR moves whenever the policy victim is consulted, even if
          // it then turns out to be locked.
          lfsr_step = lookup_valid;
          if ((policy_oh & cand) != '0) victim = policy_oh;
        end
      end

      // Fibonacci LFSR with a maximal-length tap pair for each width.
      assign lfsr_d = lfsr_step ? {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAP_MASK)} : lfsr_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= '1;
        else        lfsr_q <= lfsr_d;
      end

      if (POLICY == 1) begin : g_plru
        logic [IDX_W-1:0] hit_idx;
        logic [IDX_W-1:0] fill_idx;
        logic [NODES-1:0] plru_post [NUM_SET];

        assign hit_idx  = onehot_to_idx(hit_way);
        assign fill_idx = onehot_to_idx(fill_way);

        for (gi = 0; gi < NUM_SET; gi++) begin : g_set
          logic [NODES-1:0] plru_q;
          logic [NODES-1:0] plru_d;

          // Hit first, then fill, so the fill wins on shared nodes.
          always_comb begin
            plru_d = plru_q;
            if (hit_valid && hit_set == SET_W'(gi))
              plru_d = plru_touch(plru_d, hit_idx);
            if (fill_valid && fill_set == SET_W'(gi))
              plru_d = plru_touch(plru_d, fill_idx);
          end

          always_ff @(posedge clk or negedge reset) begin
            if (!reset) plru_q <= '0;
            else        plru_q <= plru_d;
          end

          // Post-touch state, so a same-cycle lookup sees the update.
          assign plru_post[gi] = plru_d;
        end

        assign policy_idx = plru_walk(plru_post[lookup_set]);
      end else begin : g_lfsr
        logic unused_touch;
        assign unused_touch = ^{hit_valid, hit_set, hit_way, fill_valid, fill_set, fill_way};
        assign policy_idx   = lfsr_q[IDX_W-1:0];
      end
    end
  endgenerate

endmodule

// File: tb/tb_replace_policy_unit.sv
// Bench for replace_policy_unit: one PLRU instance and one LFSR instance share
// the same stimulus; a behavioural model predicts both results every cycle.
module tb_replace_policy_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lookup_valid = 1'b0;
  logic [5:0] lookup_set = '0;
  logic [3:0] v_ways = 4'hf;
  logic       hit_valid = 1'b0;
  logic [5:0] hit_set = '0;
  logic [3:0] hit_way = 4'b0001;
  logic       fill_valid = 1'b0;
  logic [5:0] fill_set = '0;
  logic [3:0] fill_way = 4'b0001;
  logic [3:0] lock_ways = 4'h0;

  logic       rv1, rv0;
  logic [3:0] rw1, rw0;

  always #5 clk = ~clk;

  replace_policy_unit #(.NUM_WAY(4), .NUM_SET(64), .POLICY(1)) u_plru (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set), .v_ways(v_ways),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
`ifdef REPLACE_WAY_LOCK_EN
    .lock_ways(lock_ways),
`endif
    .replace_valid(rv1), .replace_way(rw1)
  );

  replace_policy_unit #(.NUM_WAY(4), .NUM_SET(64), .POLICY(0)) u_rand (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set), .v_ways(v_ways),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
`ifdef REPLACE_WAY_LOCK_EN
    .lock_ways(lock_ways),
`endif
    .replace_valid(rv0), .replace_way(rw0)
  );

  // Touch ways must be one-hot.
  always @(posedge clk) begin
    if (reset) begin
      if (hit_valid)  assert ($onehot(hit_way))  else $error("illegal hit_way %b", hit_way);
      if (fill_valid) assert ($onehot(fill_way)) else $error("illegal fill_way %b", fill_way);
    end
  end

  // ---------------- behavioural model ----------------
  bit         m_tree [64][3];   // per set: node -> 0 victim below, 1 victim above
  int         m_lfsr;
  logic       pend_v, exp_v;
  logic [3:0] pend_w1, pend_w0, exp_w1, exp_w0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  logic [3:0] seen [256];

  task automatic model_reset();
    for (int s = 0; s < 64; s++)
      for (int n = 0; n < 3; n++) m_tree[s][n] = 1'b0;
    m_lfsr  = 15;
    pend_v  = 1'b0; pend_w1 = '0; pend_w0 = '0;
    exp_v   = 1'b0; exp_w1  = '0; exp_w0  = '0;
  endtask

  function automatic int first_set(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Descend the way range [lo,hi); every node on the way marks the other half.
  task automatic model_touch(input int set, input int way);
    int lo, hi, node, mid;
    lo = 0; hi = 4; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin m_tree[set][node] = 1'b1; node = 2 * node + 1; hi = mid; end
      else           begin m_tree[set][node] = 1'b0; node = 2 * node + 2; lo = mid; end
    end
  endtask

  function automatic int model_plru_victim(input int set);
    int lo, hi, node, mid;
    lo = 0; hi = 4; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_tree[set][node] == 1'b0) begin node = 2 * node + 1; hi = mid; end
      else                           begin node = 2 * node + 2; lo = mid; end
    end
    return lo;
  endfunction

  // x^4 + x^3 + 1, shifting toward the MSB.
  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 3) ^ (s >> 2)) & 1;
    return ((s << 1) | fb) & 15;
  endfunction

  task automatic model_step();
    logic [3:0] cand, inv;
    int w1, w0, p1, p0, low;
    if (hit_valid)  model_touch(int'(hit_set),  first_set(hit_way));
    if (fill_valid) model_touch(int'(fill_set), first_set(fill_way));
    if (lookup_valid) begin
`ifdef REPLACE_WAY_LOCK_EN
      cand = ~lock_ways;
`else
      cand = 4'hf;
`endif
      if (cand == 4'h0) cand = 4'hf;
      inv = ~v_ways & cand;
      if (inv != 4'h0) begin
        w1 = first_set(inv); w0 = w1;
      end else begin
        low = first_set(cand);
        p1  = model_plru_victim(int'(lookup_set));
        p0  = m_lfsr % 4;
        w1  = cand[p1] ? p1 : low;
        w0  = cand[p0] ? p0 : low;
        m_lfsr = lfsr_next(m_lfsr);
      end
      pend_w1 = 4'(1 << w1);
      pend_w0 = 4'(1 << w0);
    end
    pend_v = lookup_valid;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit lv, input int ls, input logic [3:0] vw, input logic [3:0] lk,
                     input bit hv, input int hs, input int hw,
                     input bit fv, input int fs, input int fw);
    @(posedge clk); #1;
    exp_v = pend_v; exp_w1 = pend_w1; exp_w0 = pend_w0;
    lookup_valid = lv; lookup_set = 6'(ls); v_ways = vw; lock_ways = lk;
    hit_valid  = hv; hit_set  = 6'(hs); hit_way  = 4'(1 << hw);
    fill_valid = fv; fill_set = 6'(fs); fill_way = 4'(1 << fw);
    model_step();
  endtask

  task automatic idle();
    cyc(1'b0, 0, 4'hf, 4'h0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic look(input int s, input logic [3:0] vw, input logic [3:0] lk);
    cyc(1'b1, s, vw, lk, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    lookup_valid = 1'b0; hit_valid = 1'b0; fill_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, expv);
    end else begin
      $display("check %s: %b ok", name, act);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (rv1 !== exp_v || rv0 !== exp_v) begin
        n_fail++;
        $display("FAIL valid @%0t: plru=%b rand=%b, expected %b", $time, rv1, rv0, exp_v);
      end
      n_cmp++;
      if (rw1 !== exp_w1) begin
        n_fail++;
        $display("FAIL plru_way @%0t: got %b, expected %b", $time, rw1, exp_w1);
      end
      n_cmp++;
      if (rw0 !== exp_w0) begin
        n_fail++;
        $display("FAIL rand_way @%0t: got %b, expected %b", $time, rw0, exp_w0);
      end
      if (exp_v) $display("lookup result @%0t: plru=%b rand=%b", $time, rw1, rw0);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] acc;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // First victim after reset: PLRU way 0; LFSR 1111 -> way 3.
    look(5, 4'hf, 4'h0); idle();
    check("reset_valid", {3'b000, rv1}, 4'b0001);
    check("reset_first_plru", rw1, 4'b0001);
    check("reset_first_rand", rw0, 4'b1000);

    cyc(1'b0, 0, 4'hf, 4'h0, 1'b1, 5, 0, 1'b0, 0, 0); look(5, 4'hf, 4'h0); idle();
    check("hit_w0", rw1, 4'b0100);
    cyc(1'b0, 0, 4'hf, 4'h0, 1'b1, 5, 2, 1'b0, 0, 0); look(5, 4'hf, 4'h0); idle();
    check("hit_w2", rw1, 4'b0010);
    cyc(1'b0, 0, 4'hf, 4'h0, 1'b1, 5, 1, 1'b1, 5, 3); look(5, 4'hf, 4'h0); idle();
    check("hit_w1_fill_w3", rw1, 4'b0001);
    look(5, 4'b1011, 4'h0); idle();
    check("invalid_first_plru", rw1, 4'b0100);
    check("invalid_first_rand", rw0, 4'b0100);
    cyc(1'b1, 3, 4'hf, 4'h0, 1'b1, 3, 0, 1'b0, 0, 0); idle();
    check("bypass_hit", rw1, 4'b0100);

    // Reset with a lookup in flight: the result is dropped.
    look(7, 4'hf, 4'h0);
    do_reset();
    idle();
    check("no_pulse_after_reset", {3'b000, rv1}, 4'b0000);
    look(5, 4'hf, 4'h0); idle();
    check("post_reset_plru", rw1, 4'b0001);
    check("post_reset_rand", rw0, 4'b1000);

`ifdef REPLACE_WAY_LOCK_EN
    do_reset();
    look(9, 4'hf, 4'b0001); idle();
    check("lock_w0", rw1, 4'b0010);
    look(10, 4'hf, 4'b1111); idle();
    check("lock_all", rw1, 4'b0001);
    look(11, 4'b1110, 4'b0001); idle();
    check("lock_skips_invalid", rw1, 4'b0010);
`endif

    // 256 back-to-back random-policy lookups; every way in each 16 window.
    for (int i = 0; i < 256; i++) begin
      look($urandom_range(0, 63), 4'hf, 4'h0);
      if (i > 0) seen[i - 1] = rw0;
    end
    idle();
    seen[255] = rw0;
    for (int w = 0; w < 16; w++) begin
      acc = 4'h0;
      for (int k = 0; k < 16; k++) acc = acc | seen[w * 16 + k];
      check($sformatf("window_%0d", w), acc, 4'hf);
    end

    // Randomised mix of lookups, touches, validity and locks on few sets.
    for (int i = 0; i < 700; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          $urandom_range(0, 7),
          ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
          1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
          1'($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 3));
    end
    idle(); idle();
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
